// File: rtl/regmodel0_regmodel_core_reg_resp_arb_if.sv
// Bundle for the response sources and the merged stream toward the response buffer.
// The arbiter connects through the master modport and the source/sink side through slave.
interface regmodel0_regmodel_core_reg_resp_arb_if #(
    parameter int NUM_REQ   = 4,
    parameter int PAYLOAD_W = 34
);
    logic [NUM_REQ-1:0]           req_valid_i;
    logic [NUM_REQ*PAYLOAD_W-1:0] req_payload_i;
    logic [NUM_REQ-1:0]           req_ready_o;
    logic [NUM_REQ-1:0]           req_mask_i;
    logic                         valid_o;
    logic [PAYLOAD_W-1:0]         payload_o;
    logic                         ready_i;

    modport master (
        input  req_valid_i, req_payload_i, req_mask_i, ready_i,
        output req_ready_o, valid_o, payload_o
    );

    modport slave (
        output req_valid_i, req_payload_i, req_mask_i, ready_i,
        input  req_ready_o, valid_o, payload_o
    );
endinterface

// File: rtl/regmodel0_regmodel_core_reg_resp_arb.sv
// Round-robin merge of register response sources into one stream.
// The grant is zero-latency in IDLE and is locked in HOLD while the sink stalls.
//
// state | meaning
// IDLE  | combinational pass-through of the round-robin winner
// HOLD  | winner stalled by sink; grant frozen on hold_id until accepted
module regmodel0_regmodel_core_reg_resp_arb #(
    parameter int NUM_REQ   = 4,
    parameter int PAYLOAD_W = 34,
    parameter int TMO_W     = 8
) (
    input  logic                       payload_cgm_clk,
    input  logic                       hw_reset_n,
    input  logic                       func_reset_n,
    regmodel0_regmodel_core_reg_resp_arb_if.master bus,
    input  logic [TMO_W-1:0]           tmo_cfg_i,
    output logic                       stall_err_o,
    input  logic                       stall_err_clr_i,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       busy_o
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t               state;
    logic [ID_W-1:0]      ptr;
    logic [ID_W-1:0]      hold_id;
    logic [TMO_W-1:0]     stall_cnt;
    logic [NUM_REQ-1:0]   elig;
    logic                 any_elig;
    logic [ID_W-1:0]      sel;
    logic [ID_W-1:0]      cur_id;
    logic [ID_W:0]        raw;
    logic [ID_W-1:0]      idx;
    logic [PAYLOAD_W-1:0] payload_arr [NUM_REQ];

    assign elig     = bus.req_valid_i & ~bus.req_mask_i;
    assign any_elig = |elig;
    assign cur_id   = (state == HOLD) ? hold_id : sel;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_split
        assign payload_arr[k] = bus.req_payload_i[k*PAYLOAD_W +: PAYLOAD_W];
    end

    // Scan from the farthest offset down so the nearest eligible source after ptr wins.
    always_comb begin
        sel = '0;
        raw = '0;
        idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            raw = {1'b0, ptr} + (ID_W+1)'(i);
            idx = (raw >= (ID_W+1)'(NUM_REQ)) ? ID_W'(raw - (ID_W+1)'(NUM_REQ))
                                               : raw[ID_W-1:0];
            if (elig[idx]) sel = idx;
        end
    end

    always_comb begin
        bus.valid_o     = 1'b0;
        bus.req_ready_o = '0;
        bus.payload_o   = payload_arr[cur_id];
        grant_id_o      = cur_id;
        busy_o          = 1'b0;
        if (func_reset_n) begin
            if (state == HOLD) begin
                bus.valid_o                  = 1'b1;
                bus.req_ready_o[hold_id]     = bus.ready_i;
                busy_o                       = 1'b1;
            end else if (any_elig) begin
                bus.valid_o                  = 1'b1;
                bus.req_ready_o[sel]         = bus.ready_i;
            end
        end
    end

    always_ff @(posedge payload_cgm_clk or negedge hw_reset_n) begin
        if (!hw_reset_n) begin
            state       <= IDLE;
            ptr         <= ID_W'(NUM_REQ - 1);
            hold_id     <= '0;
            stall_cnt   <= '0;
            stall_err_o <= 1'b0;
        end else if (!func_reset_n) begin
            state       <= IDLE;
            ptr         <= ID_W'(NUM_REQ - 1);
            hold_id     <= '0;
            stall_cnt   <= '0;
            stall_err_o <= 1'b0;
        end else begin
            // Set wins over a coincident clear so a timeout is never lost.
            if ((tmo_cfg_i != '0) && (stall_cnt == tmo_cfg_i)) begin
                stall_err_o <= 1'b1;
            end else if (stall_err_clr_i) begin
                stall_err_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    stall_cnt <= '0;
                    if (any_elig) begin
                        if (bus.ready_i) begin
                            ptr <= sel;
                        end else begin
                            state   <= HOLD;
                            hold_id <= sel;
                        end
                    end
                end
                HOLD: begin
                    if (bus.ready_i) begin
                        ptr       <= hold_id;
                        state     <= IDLE;
                        stall_cnt <= '0;
                    end else if (stall_cnt != '1) begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regmodel0_regmodel_core_reg_resp_arb.sv
// Directed bench for the response arbiter: round-robin order, stalls, masking,
// stall timeout and functional reset, all against hand-computed expectations.
module tb_regmodel0_regmodel_core_reg_resp_arb;
    localparam int NUM_REQ   = 4;
    localparam int PAYLOAD_W = 34;
    localparam int TMO_W     = 8;

    logic             payload_cgm_clk = 1'b0;
    logic             hw_reset_n;
    logic             func_reset_n;
    logic [TMO_W-1:0] tmo_cfg_i;
    logic             stall_err_o;
    logic             stall_err_clr_i;
    logic [1:0]       grant_id_o;
    logic             busy_o;

    int n_cmp = 0;
    int n_mis = 0;

    regmodel0_regmodel_core_reg_resp_arb_if #(.NUM_REQ(NUM_REQ), .PAYLOAD_W(PAYLOAD_W)) bus ();

    regmodel0_regmodel_core_reg_resp_arb #(
        .NUM_REQ(NUM_REQ), .PAYLOAD_W(PAYLOAD_W), .TMO_W(TMO_W)
    ) dut (
        .payload_cgm_clk(payload_cgm_clk),
        .hw_reset_n     (hw_reset_n),
        .func_reset_n   (func_reset_n),
        .bus            (bus.master),
        .tmo_cfg_i      (tmo_cfg_i),
        .stall_err_o    (stall_err_o),
        .stall_err_clr_i(stall_err_clr_i),
        .grant_id_o     (grant_id_o),
        .busy_o         (busy_o)
    );

    always #5 payload_cgm_clk = ~payload_cgm_clk;

    function automatic logic [PAYLOAD_W-1:0] pl(input int k);
        return {2'(k + 1), 32'hA5A5_0000 + 32'(k)};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input bit v, input logic [3:0] rdy,
                              input int g, input bit busy);
        check_eq({tag, ".valid"}, 64'(bus.valid_o), 64'(v));
        check_eq({tag, ".ready"}, 64'(bus.req_ready_o), 64'(rdy));
        check_eq({tag, ".grant"}, 64'(grant_id_o), 64'(g));
        check_eq({tag, ".busy"}, 64'(busy_o), 64'(busy));
        if (v) check_eq({tag, ".payload"}, 64'(bus.payload_o), 64'(pl(g)));
    endtask

    task automatic tick();
        @(posedge payload_cgm_clk);
        #1;
    endtask

    initial begin
        hw_reset_n          = 1'b0;
        func_reset_n        = 1'b1;
        tmo_cfg_i           = '0;
        stall_err_clr_i     = 1'b0;
        bus.req_valid_i     = '0;
        bus.req_mask_i      = '0;
        bus.ready_i         = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) bus.req_payload_i[k*PAYLOAD_W +: PAYLOAD_W] = pl(k);
        tick();
        tick();
        expect_out("rst", 0, 4'b0000, 0, 0);
        check_eq("rst.err", 64'(stall_err_o), 64'd0);
        hw_reset_n = 1'b1;
        tick();

        // Round robin from reset pointer: 0,1,2,3,0
        bus.req_valid_i = 4'hF;
        bus.ready_i     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 expect_out($sformatf("rr%0d", i), 1, 4'(1 << (i % 4)), i % 4, 0);
            tick();
        end

        func_reset_n = 1'b0;
        #1;
        check_eq("frst.valid", 64'(bus.valid_o), 64'd0);
        check_eq("frst.ready", 64'(bus.req_ready_o), 64'd0);
        tick();
        func_reset_n    = 1'b1;
        bus.req_valid_i = '0;
        bus.ready_i     = 1'b0;

        // Source 2 stalled three cycles, source 0 arrives meanwhile
        bus.req_valid_i = 4'b0100;
        #1 expect_out("st0", 1, 4'b0000, 2, 0);
        tick();
        bus.req_valid_i = 4'b0101;
        #1 expect_out("st1", 1, 4'b0000, 2, 1);
        tick();
        #1 expect_out("st2", 1, 4'b0000, 2, 1);
        tick();
        bus.ready_i = 1'b1;
        #1 expect_out("st3", 1, 4'b0100, 2, 1);
        tick();
        bus.req_valid_i = 4'b0001;
        #1 expect_out("st4", 1, 4'b0001, 0, 0);
        tick();
        bus.req_valid_i = '0;
        #1 expect_out("none", 0, 4'b0000, 0, 0);

        // Mask 0101: alternation 1,3,1,3 (pointer starts at 0)
        bus.req_mask_i  = 4'b0101;
        bus.req_valid_i = 4'hF;
        for (int i = 0; i < 4; i++) begin
            #1 expect_out($sformatf("mask%0d", i), 1, (i % 2 == 0) ? 4'b0010 : 4'b1000,
                          (i % 2 == 0) ? 1 : 3, 0);
            tick();
        end
        bus.req_mask_i = 4'hF;
        #1 expect_out("allmask", 0, 4'b0000, 0, 0);
        tick();
        bus.req_mask_i = '0;
        #1 expect_out("wrap", 1, 4'b0001, 0, 0);
        tick();
        bus.req_valid_i = '0;
        bus.ready_i     = 1'b0;

        // Timeout 5: flag visible from the 8th stalled cycle observation (index 7)
        tmo_cfg_i       = 8'd5;
        bus.req_valid_i = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq($sformatf("tmo%0d.busy", i), 64'(busy_o), 64'(i >= 1));
            check_eq($sformatf("tmo%0d.grant", i), 64'(grant_id_o), 64'd1);
            check_eq($sformatf("tmo%0d.err", i), 64'(stall_err_o), 64'(i >= 7));
            tick();
        end
        bus.ready_i = 1'b1;
        #1 expect_out("tmo_acc", 1, 4'b0010, 1, 1);
        tick();
        bus.req_valid_i = '0;
        bus.ready_i     = 1'b0;
        #1 check_eq("tmo.sticky", 64'(stall_err_o), 64'd1);
        stall_err_clr_i = 1'b1;
        tick();
        stall_err_clr_i = 1'b0;
        #1 check_eq("tmo.clr", 64'(stall_err_o), 64'd0);

        // Timeout disabled
        tmo_cfg_i       = 8'd0;
        bus.req_valid_i = 4'b0100;
        repeat (6) tick();
        check_eq("tmo0.err", 64'(stall_err_o), 64'd0);
        check_eq("tmo0.busy", 64'(busy_o), 64'd1);
        bus.ready_i = 1'b1;
        tick();
        bus.req_valid_i = '0;
        bus.ready_i     = 1'b0;

        // Timeout 1 with clear asserted in the same cycle the flag sets
        tmo_cfg_i       = 8'd1;
        bus.req_valid_i = 4'b0001;
        tick();
        tick();
        stall_err_clr_i = 1'b1;
        tick();
        stall_err_clr_i = 1'b0;
        #1 check_eq("setclr.err", 64'(stall_err_o), 64'd1);
        bus.ready_i = 1'b1;
        tick();
        bus.req_valid_i = '0;
        bus.ready_i     = 1'b0;
        stall_err_clr_i = 1'b1;
        tick();
        stall_err_clr_i = 1'b0;
        tmo_cfg_i       = 8'd0;
        #1 check_eq("setclr.cleared", 64'(stall_err_o), 64'd0);

        // Functional reset during HOLD on source 3
        bus.req_valid_i = 4'b1000;
        #1 expect_out("fr0", 1, 4'b0000, 3, 0);
        tick();
        bus.req_valid_i = 4'b1001;
        #1 expect_out("fr1", 1, 4'b0000, 3, 1);
        tick();
        func_reset_n = 1'b0;
        #1;
        check_eq("fr.valid", 64'(bus.valid_o), 64'd0);
        check_eq("fr.ready", 64'(bus.req_ready_o), 64'd0);
        check_eq("fr.busy", 64'(busy_o), 64'd0);
        tick();
        func_reset_n = 1'b1;
        bus.ready_i  = 1'b1;
        #1 expect_out("fr_after", 1, 4'b0001, 0, 0);
        tick();
        bus.req_valid_i = '0;
        bus.ready_i     = 1'b0;

        // Masking the held source mid-HOLD
        bus.req_valid_i = 4'b0010;
        #1 expect_out("mk0", 1, 4'b0000, 1, 0);
        tick();
        bus.req_mask_i  = 4'b0010;
        bus.req_valid_i = 4'b0110;
        #1 expect_out("mk1", 1, 4'b0000, 1, 1);
        tick();
        bus.ready_i = 1'b1;
        #1 expect_out("mk2", 1, 4'b0010, 1, 1);
        tick();
        bus.req_valid_i = 4'b0010;
        #1 expect_out("mk3", 0, 4'b0000, 0, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
